// File: rtl/subsistema_calculo.sv
// -----------------------------------------------------------------------------
// subsistema_calculo
//
// Iterative 4x4 shift-add multiplier. It accepts a pair of operands with a
// level-high request, runs four shift-add steps (one per multiplier bit, LSB
// first) and presents a registered 8-bit product while holding in LISTO.
//
// Ports
//   reloj          : clock, every state update happens on its rising edge
//   reinicio       : synchronous active-high reset, highest priority
//   operandoA[3:0] : multiplicand, captured only on acceptance
//   operandoB[3:0] : multiplier, captured only on acceptance
//   banderaValida  : level-high request, operands are valid
//   producto[7:0]  : registered product
//   banderaListo   : high while the result is available (LISTO)
//   ocupado        : high while the iterative calculation runs (CALCULO)
//   estado[1:0]    : current FSM encoding (ESPERA=00, CALCULO=01, LISTO=10)
//
// Configuration
//   MULT_SIGNED_EN : when defined, operands and product are two's complement
//                    and the step for multiplier bit 3 subtracts the shifted,
//                    sign-extended multiplicand. When undefined the datapath
//                    is purely unsigned and has no subtract path.
// -----------------------------------------------------------------------------
module subsistema_calculo (
    input  logic       reloj,
    input  logic       reinicio,
    input  logic [3:0] operandoA,
    input  logic [3:0] operandoB,
    input  logic       banderaValida,
    output logic [7:0] producto,
    output logic       banderaListo,
    output logic       ocupado,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        ESPERA   = 2'b00,
        CALCULO  = 2'b01,
        LISTO    = 2'b10,
        INVALIDO = 2'b11
    } estadoT;

    estadoT     estadoActual;
    estadoT     estadoSiguiente;

    logic [3:0] regA;
    logic [3:0] regANext;
    logic [3:0] regB;
    logic [3:0] regBNext;
    logic [7:0] acumulador;
    logic [7:0] acumuladorNext;
    logic [1:0] contador;
    logic [1:0] contadorNext;
    logic [7:0] productoReg;
    logic [7:0] productoNext;

    logic [7:0] multiplicandoExt;
    logic [7:0] sumando;
    logic       bitActual;
    logic [7:0] acumuladorPaso;

    // The multiplicand is widened to the accumulator width before shifting.
    // In signed mode it is sign-extended so negative partial products are
    // represented correctly in 8-bit two's complement.
`ifdef MULT_SIGNED_EN
    assign multiplicandoExt = {{4{regA[3]}}, regA};
`else
    assign multiplicandoExt = {4'b0000, regA};
`endif

    assign sumando   = multiplicandoExt << contador;
    assign bitActual = regB[contador];

    // One shift-add step for the multiplier bit selected by the counter.
    // In signed mode bit 3 carries negative weight, so that step subtracts
    // instead of adding. The unsigned build has only the adder.
    always_comb begin
        acumuladorPaso = acumulador;
        if (bitActual) begin
`ifdef MULT_SIGNED_EN
            if (contador == 2'd3) begin
                acumuladorPaso = acumulador - sumando;
            end else begin
                acumuladorPaso = acumulador + sumando;
            end
`else
            acumuladorPaso = acumulador + sumando;
`endif
        end
    end

    // Next-state and datapath update logic. Everything holds by default;
    // each state only overrides what it changes. The unused encoding 11
    // falls into the default branch and returns to ESPERA.
    always_comb begin
        estadoSiguiente = estadoActual;
        regANext        = regA;
        regBNext        = regB;
        acumuladorNext  = acumulador;
        contadorNext    = contador;
        productoNext    = productoReg;

        case (estadoActual)
            ESPERA: begin
                if (banderaValida) begin
                    regANext        = operandoA;
                    regBNext        = operandoB;
                    acumuladorNext  = 8'h00;
                    contadorNext    = 2'd0;
                    productoNext    = 8'h00;
                    estadoSiguiente = CALCULO;
                end
            end

            CALCULO: begin
                acumuladorNext = acumuladorPaso;
                contadorNext   = contador + 2'd1;
                if (contador == 2'd3) begin
                    productoNext    = acumuladorPaso;
                    estadoSiguiente = LISTO;
                end
            end

            LISTO: begin
                if (!banderaValida) begin
                    estadoSiguiente = ESPERA;
                end
            end

            default: begin
                estadoSiguiente = ESPERA;
            end
        endcase
    end

    // State and datapath registers. Reset is synchronous and wins over
    // everything, so an operation in progress is simply abandoned.
    always_ff @(posedge reloj) begin
        if (reinicio) begin
            estadoActual <= ESPERA;
            regA         <= 4'h0;
            regB         <= 4'h0;
            acumulador   <= 8'h00;
            contador     <= 2'd0;
            productoReg  <= 8'h00;
        end else begin
            estadoActual <= estadoSiguiente;
            regA         <= regANext;
            regB         <= regBNext;
            acumulador   <= acumuladorNext;
            contador     <= contadorNext;
            productoReg  <= productoNext;
        end
    end

    // Status outputs are decoded straight from the state register, so they
    // change on the same edge as the state itself.
    assign producto     = productoReg;
    assign ocupado      = (estadoActual == CALCULO);
    assign banderaListo = (estadoActual == LISTO);
    assign estado       = estadoActual;

endmodule

// File: tb/tb_subsistema_calculo.sv
// -----------------------------------------------------------------------------
// tb_subsistema_calculo
//
// Directed testbench for subsistema_calculo. Stimulus pushes the hand-computed
// product into a queue; an independent monitor pops and compares it whenever
// banderaListo rises. The stimulus side also checks cycle-level status
// (ocupado for exactly four cycles, LISTO holding, return to ESPERA, reset).
// Vectors follow MULT_SIGNED_EN so the same bench covers both builds.
// -----------------------------------------------------------------------------
module tb_subsistema_calculo;

    logic       reloj = 1'b0;
    logic       reinicio;
    logic [3:0] operandoA;
    logic [3:0] operandoB;
    logic       banderaValida;
    logic [7:0] producto;
    logic       banderaListo;
    logic       ocupado;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;

    logic [7:0] colaEsperada[$];
    logic       listoPrevio = 1'b0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
        int         hold;
    } vectorT;

    vectorT vectores[7];

    subsistema_calculo dut (
        .reloj         (reloj),
        .reinicio      (reinicio),
        .operandoA     (operandoA),
        .operandoB     (operandoB),
        .banderaValida (banderaValida),
        .producto      (producto),
        .banderaListo  (banderaListo),
        .ocupado       (ocupado),
        .estado        (estado)
    );

    // Free-running clock, 10 time units per period.
    always #5 reloj = ~reloj;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string nombre, input logic [7:0] actual,
                               input logic [7:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%02h expected=0x%02h", nombre, actual, esperado);
        end
    endtask

    // Scoreboard monitor: on each rising banderaListo, pop the oldest
    // expected product and compare it with the DUT output.
    always @(negedge reloj) begin
        if (banderaListo && !listoPrevio) begin
            if (colaEsperada.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL resultado_inesperado actual=0x%02h expected=none", producto);
            end else begin
                checkOutput("producto_scoreboard", producto, colaEsperada.pop_front());
            end
        end
        listoPrevio = banderaListo;
    end

    // Follows one accepted operation from the cycle after the acceptance
    // edge: four busy cycles with scrambled inputs, LISTO for 'hold' extra
    // cycles with the request held, then release back to ESPERA.
    task automatic esperarResultado(input logic [7:0] esperado, input int hold);
        for (int i = 0; i < 4; i++) begin
            @(negedge reloj);
            checkOutput("ocupado_calculo", {7'b0, ocupado}, 8'h01);
            checkOutput("listo_en_calculo", {7'b0, banderaListo}, 8'h00);
            checkOutput("estado_calculo", {6'b0, estado}, 8'h01);
            operandoA     = 4'($urandom);
            operandoB     = 4'($urandom);
            banderaValida = 1'($urandom_range(0, 1));
        end
        @(negedge reloj);
        checkOutput("listo_tras_4", {7'b0, banderaListo}, 8'h01);
        checkOutput("ocupado_tras_4", {7'b0, ocupado}, 8'h00);
        checkOutput("estado_listo", {6'b0, estado}, 8'h02);
        checkOutput("producto_directo", producto, esperado);
        banderaValida = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge reloj);
            checkOutput("listo_retenido", {6'b0, estado}, 8'h02);
            checkOutput("ocupado_retenido", {7'b0, ocupado}, 8'h00);
            checkOutput("producto_retenido", producto, esperado);
        end
        banderaValida = 1'b0;
        @(negedge reloj);
        checkOutput("estado_espera", {6'b0, estado}, 8'h00);
        checkOutput("listo_liberado", {7'b0, banderaListo}, 8'h00);
        checkOutput("producto_tras_liberar", producto, esperado);
        @(negedge reloj);
        checkOutput("producto_en_espera", producto, esperado);
        checkOutput("estado_espera_quieto", {6'b0, estado}, 8'h00);
    endtask

    // Presents one operand pair for a single acceptance edge.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] esperado, input int hold);
        @(negedge reloj);
        operandoA     = a;
        operandoB     = b;
        banderaValida = 1'b1;
        colaEsperada.push_back(esperado);
        esperarResultado(esperado, hold);
    endtask

    initial begin
`ifdef MULT_SIGNED_EN
        vectores = '{
            '{4'h8, 4'h8, 8'h40, 0},
            '{4'hF, 4'h7, 8'hF9, 0},
            '{4'h0, 4'h9, 8'h00, 0},
            '{4'h3, 4'h5, 8'h0F, 8},
            '{4'h2, 4'h6, 8'h0C, 0},
            '{4'h7, 4'hB, 8'hDD, 0},
            '{4'h9, 4'h8, 8'h38, 1}
        };
`else
        vectores = '{
            '{4'hF, 4'hF, 8'hE1, 0},
            '{4'h0, 4'h9, 8'h00, 0},
            '{4'h3, 4'h5, 8'h0F, 8},
            '{4'h2, 4'h6, 8'h0C, 0},
            '{4'h7, 4'hB, 8'h4D, 0},
            '{4'h9, 4'h8, 8'h48, 1},
            '{4'h1, 4'h1, 8'h01, 0}
        };
`endif

        reinicio      = 1'b1;
        banderaValida = 1'b0;
        operandoA     = 4'h0;
        operandoB     = 4'h0;
        repeat (2) @(negedge reloj);
        checkOutput("reset_estado", {6'b0, estado}, 8'h00);
        checkOutput("reset_producto", producto, 8'h00);
        checkOutput("reset_listo", {7'b0, banderaListo}, 8'h00);
        checkOutput("reset_ocupado", {7'b0, ocupado}, 8'h00);
        reinicio = 1'b0;

        @(negedge reloj);
        checkOutput("espera_sin_valida", {6'b0, estado}, 8'h00);

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vectores[v].a, vectores[v].b, vectores[v].p, vectores[v].hold);
        end

        // Abort in the second CALCULO cycle, with no result expected.
        @(negedge reloj);
        operandoA     = 4'h5;
        operandoB     = 4'h5;
        banderaValida = 1'b1;
        @(negedge reloj);
        checkOutput("aborto_en_calculo", {6'b0, estado}, 8'h01);
        banderaValida = 1'b0;
        @(negedge reloj);
        checkOutput("aborto_segundo_ciclo", {7'b0, ocupado}, 8'h01);
        reinicio = 1'b1;
        @(negedge reloj);
        checkOutput("aborto_estado", {6'b0, estado}, 8'h00);
        checkOutput("aborto_producto", producto, 8'h00);
        checkOutput("aborto_ocupado", {7'b0, ocupado}, 8'h00);
        checkOutput("aborto_listo", {7'b0, banderaListo}, 8'h00);

        // Reset still asserted with a request pending: reset must win.
        banderaValida = 1'b1;
        operandoA     = 4'h4;
        operandoB     = 4'h3;
        @(negedge reloj);
        checkOutput("reset_prioridad", {6'b0, estado}, 8'h00);

        // Reset falls with the request high: accepted on the very next edge.
        reinicio = 1'b0;
        colaEsperada.push_back(8'h0C);
        esperarResultado(8'h0C, 0);

        repeat (2) @(negedge reloj);
        checkOutput("cola_vacia", 8'(colaEsperada.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
